matrix_line_ctrl: RTL and testbench

MATRIX_LINE_CTRL -- requirements
Module: matrix_line_ctrl

---
 rtl/matrix_line_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_matrix_line_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_line_ctrl.sv
// 3x3 sliding-window controller: streams pixels through two external line FIFOs
// and emits one window per RUN pixel from column 2 onward, then drains the FIFOs.
module matrix_line_ctrl #(
    parameter int IMG_W  = 416,
    parameter int IMG_H  = 416,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    input  logic                  in_sof,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_rdy,
    output logic                  f0_wr_en,
    output logic [DATA_W-1:0]     f0_wr_data,
    output logic                  f1_wr_en,
    output logic [DATA_W-1:0]     f1_wr_data,
    output logic                  f0_rd_en,
    output logic                  f1_rd_en,
    input  logic                  f0_rd_vld,
    input  logic [DATA_W-1:0]     f0_rd_data,
    input  logic                  f1_rd_vld,
    input  logic [DATA_W-1:0]     f1_rd_data,
    output logic                  win_vld,
    output logic [9*DATA_W-1:0]   win_data,
    output logic                  frame_done,
    output logic                  sof_err
);

    localparam logic [9:0]  COL_LAST_C = 10'(IMG_W - 1);
    localparam logic [11:0] ROW_LAST_C = 12'(IMG_H - 1);
    localparam logic [10:0] POP_FULL_C = 11'(IMG_W);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL0 = 3'd1,
        ST_FILL1 = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [9:0]          col_r;
    logic [11:0]         row_r;
    logic [10:0]         pop0_r;
    logic [10:0]         pop1_r;
    logic [10:0]         pop0_nxt_s;
    logic [10:0]         pop1_nxt_s;
    logic                rdy_s;
    logic                acc_s;
    logic                line_end_s;
    logic                wr0_s;
    logic                wr1_s;
    logic                rd0_s;
    logic                rd1_s;
    logic                shift_s;
    logic                win_load_s;
    logic                done_s;
    logic                sof_bad_s;
    logic [DATA_W-1:0]   top_tap_s;
    logic [DATA_W-1:0]   mid_tap_s;
    logic [DATA_W-1:0]   win_r     [9];
    logic [DATA_W-1:0]   win_nxt_s [9];
    logic [9*DATA_W-1:0] win_pack_s;
    logic [9*DATA_W-1:0] win_data_r;
    logic                win_vld_r;
    logic                frame_done_r;
    logic                sof_err_r;

    // Input readiness: a pixel can only be taken when every FIFO it pops has a head word.
    always_comb begin
        rdy_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_FILL0: rdy_s = 1'b1;
            ST_FILL1:          rdy_s = f0_rd_vld;
            ST_RUN:            rdy_s = f0_rd_vld & f1_rd_vld;
            ST_DRAIN:          rdy_s = 1'b0;
            default:           rdy_s = 1'b0;
        endcase
    end

    assign acc_s      = in_vld & rdy_s & ~rst;
    assign line_end_s = (col_r == COL_LAST_C);

    // Next-state, FIFO strobes, tap selection and drain bookkeeping.
    always_comb begin
        state_nxt_s = state_r;
        wr0_s       = 1'b0;
        wr1_s       = 1'b0;
        rd0_s       = 1'b0;
        rd1_s       = 1'b0;
        shift_s     = 1'b0;
        win_load_s  = 1'b0;
        done_s      = 1'b0;
        sof_bad_s   = 1'b0;
        top_tap_s   = {DATA_W{1'b0}};
        mid_tap_s   = {DATA_W{1'b0}};
        pop0_nxt_s  = pop0_r;
        pop1_nxt_s  = pop1_r;
        case (state_r)
            ST_IDLE: begin
                // The SOF pixel itself is row 0 / column 0 and is stored like any FILL0 pixel.
                if (acc_s && in_sof) begin
                    wr0_s       = 1'b1;
                    shift_s     = 1'b1;
                    state_nxt_s = ST_FILL0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL0: begin
                if (acc_s) begin
                    wr0_s     = 1'b1;
                    shift_s   = 1'b1;
                    sof_bad_s = in_sof;
                    if (line_end_s) begin
                        state_nxt_s = ST_FILL1;
                    end else begin
                        state_nxt_s = ST_FILL0;
                    end
                end else begin
                    state_nxt_s = ST_FILL0;
                end
            end
            ST_FILL1: begin
                if (acc_s) begin
                    wr0_s     = 1'b1;
                    wr1_s     = 1'b1;
                    rd0_s     = 1'b1;
                    shift_s   = 1'b1;
                    sof_bad_s = in_sof;
                    mid_tap_s = f0_rd_data;
                    if (line_end_s) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_FILL1;
                    end
                end else begin
                    state_nxt_s = ST_FILL1;
                end
            end
            ST_RUN: begin
                if (acc_s) begin
                    wr0_s      = 1'b1;
                    wr1_s      = 1'b1;
                    rd0_s      = 1'b1;
                    rd1_s      = 1'b1;
                    shift_s    = 1'b1;
                    sof_bad_s  = in_sof;
                    mid_tap_s  = f0_rd_data;
                    top_tap_s  = f1_rd_data;
                    win_load_s = (col_r >= 10'd2);
                    if (line_end_s && (row_r == ROW_LAST_C)) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Each FIFO still holds exactly one line; pop it independently of the other.
                rd0_s      = f0_rd_vld & (pop0_r < POP_FULL_C);
                rd1_s      = f1_rd_vld & (pop1_r < POP_FULL_C);
                pop0_nxt_s = pop0_r + {10'd0, rd0_s};
                pop1_nxt_s = pop1_r + {10'd0, rd1_s};
                if ((pop0_nxt_s == POP_FULL_C) && (pop1_nxt_s == POP_FULL_C)) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Shifted window and its packed form, oldest row/column in the MSBs.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_nxt_s[r*3]     = win_r[r*3+1];
            win_nxt_s[r*3+1]   = win_r[r*3+2];
        end
        win_nxt_s[2] = top_tap_s;
        win_nxt_s[5] = mid_tap_s;
        win_nxt_s[8] = in_data;
        win_pack_s   = {(9*DATA_W){1'b0}};
        for (int i = 0; i < 9; i++) begin
            win_pack_s[(8-i)*DATA_W +: DATA_W] = win_nxt_s[i];
        end
    end

    // FSM state, pixel position and drain pop counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            col_r   <= 10'd0;
            row_r   <= 12'd0;
            pop0_r  <= 11'd0;
            pop1_r  <= 11'd0;
        end else begin
            state_r <= state_nxt_s;
            pop0_r  <= done_s ? 11'd0 : pop0_nxt_s;
            pop1_r  <= done_s ? 11'd0 : pop1_nxt_s;
            if (done_s) begin
                col_r <= 10'd0;
                row_r <= 12'd0;
            end else if (shift_s) begin
                if (state_r == ST_IDLE) begin
                    col_r <= 10'd1;
                    row_r <= 12'd0;
                end else if (line_end_s) begin
                    col_r <= 10'd0;
                    row_r <= (row_r == ROW_LAST_C) ? 12'd0 : row_r + 12'd1;
                end else begin
                    col_r <= col_r + 10'd1;
                end
            end
        end
    end

    // Window shift registers and the held output window.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                win_r[i] <= {DATA_W{1'b0}};
            end
            win_data_r <= {(9*DATA_W){1'b0}};
            win_vld_r  <= 1'b0;
        end else begin
            if (shift_s) begin
                win_r <= win_nxt_s;
            end
            if (win_load_s) begin
                win_data_r <= win_pack_s;
            end
            win_vld_r <= win_load_s;
        end
    end

    // Frame completion pulse and sticky mid-frame SOF flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done_r <= 1'b0;
            sof_err_r    <= 1'b0;
        end else begin
            frame_done_r <= done_s;
            if (sof_bad_s) begin
                sof_err_r <= 1'b1;
            end
        end
    end

    assign in_rdy     = rdy_s & ~rst;
    assign f0_wr_en   = wr0_s & ~rst;
    assign f1_wr_en   = wr1_s & ~rst;
    assign f0_rd_en   = rd0_s & ~rst;
    assign f1_rd_en   = rd1_s & ~rst;
    assign f0_wr_data = in_data;
    assign f1_wr_data = f0_rd_data;
    assign win_vld    = win_vld_r;
    assign win_data   = win_data_r;
    assign frame_done = frame_done_r;
    assign sof_err    = sof_err_r;

endmodule

// File: tb/tb_matrix_line_ctrl.sv
// Bench for matrix_line_ctrl on a 4x3 image with prefetching line-FIFO models;
// expected windows are queued as pixels are driven and matched against captured windows.
module tb_matrix_line_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_vld = 1'b0;
    logic            in_sof = 1'b0;
    logic [DW-1:0]   in_data = '0;
    logic            in_rdy;
    logic            f0_wr_en, f1_wr_en, f0_rd_en, f1_rd_en;
    logic [DW-1:0]   f0_wr_data, f1_wr_data;
    logic            f0_rd_vld = 1'b0;
    logic            f1_vld_m = 1'b0;
    logic            f1_hold = 1'b0;
    logic            f1_rd_vld;
    logic [DW-1:0]   f0_rd_data = '0;
    logic [DW-1:0]   f1_rd_data = '0;
    logic            win_vld;
    logic [9*DW-1:0] win_data;
    logic            frame_done;
    logic            sof_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign f1_rd_vld = f1_vld_m & ~f1_hold;

    matrix_line_ctrl #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_sof(in_sof), .in_data(in_data), .in_rdy(in_rdy),
        .f0_wr_en(f0_wr_en), .f0_wr_data(f0_wr_data),
        .f1_wr_en(f1_wr_en), .f1_wr_data(f1_wr_data),
        .f0_rd_en(f0_rd_en), .f1_rd_en(f1_rd_en),
        .f0_rd_vld(f0_rd_vld), .f0_rd_data(f0_rd_data),
        .f1_rd_vld(f1_rd_vld), .f1_rd_data(f1_rd_data),
        .win_vld(win_vld), .win_data(win_data),
        .frame_done(frame_done), .sof_err(sof_err)
    );

    // Line FIFO models: head word becomes visible the cycle after it is written.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int proto_err = 0;
    always @(posedge clk) begin
        if (rst) begin
            if (f0_wr_en || f1_wr_en || f0_rd_en || f1_rd_en) proto_err++;
            q0.delete();
            q1.delete();
            f0_rd_vld  <= 1'b0;
            f1_vld_m   <= 1'b0;
            f0_rd_data <= '0;
            f1_rd_data <= '0;
        end else begin
            if (f0_rd_en) begin
                if (!f0_rd_vld || q0.size() == 0) proto_err++;
                else void'(q0.pop_front());
            end
            if (f1_rd_en) begin
                if (!f1_rd_vld || q1.size() == 0) proto_err++;
                else void'(q1.pop_front());
            end
            if (f0_wr_en) begin
                q0.push_back(f0_wr_data);
                if (q0.size() > W) proto_err++;
            end
            if (f1_wr_en) begin
                q1.push_back(f1_wr_data);
                if (q1.size() > W) proto_err++;
            end
            f0_rd_vld  <= (q0.size() > 0);
            f1_vld_m   <= (q1.size() > 0);
            f0_rd_data <= (q0.size() > 0) ? q0[0] : '0;
            f1_rd_data <= (q1.size() > 0) ? q1[0] : '0;
        end
    end

    // Output monitor: captures windows and counts strobes away from the clock edge.
    int cyc = 0, wr0_n = 0, wr1_n = 0, pop0_n = 0, pop1_n = 0;
    int done_n = 0, done_cyc = 0, pop_cyc = 0;
    logic [9*DW-1:0] got_q[$];
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (f0_wr_en) wr0_n++;
            if (f1_wr_en) wr1_n++;
            if (f0_rd_en) pop0_n++;
            if (f1_rd_en) pop1_n++;
            if (f0_rd_en || f1_rd_en) pop_cyc = cyc;
            if (frame_done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (win_vld) got_q.push_back(win_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9*DW-1:0] exp_win(input int base, input int c);
        logic [9*DW-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < 3; j++)
                w[(8 - (r*3 + j))*DW +: DW] = DW'(base + r*W + (c - 2 + j) + 1);
        return w;
    endfunction

    // Drive one pixel from posedge+1 and hold it until accepted; returns at posedge+1.
    task automatic send_px(input logic [DW-1:0] d, input logic sof, output bit ok);
        int budget;
        budget = 50;
        ok = 1'b0;
        in_vld = 1'b1;
        in_data = d;
        in_sof = sof;
        while (budget > 0) begin
            @(negedge clk);
            if (in_rdy) begin
                ok = 1'b1;
                break;
            end
            budget--;
        end
        @(posedge clk); #1;
        in_vld = 1'b0;
        in_sof = 1'b0;
        chk("accept", ok, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        in_vld = 1'b0;
        in_sof = 1'b0;
        f1_hold = 1'b0;
        @(negedge clk);
        chk("rst_fifo_en", {f0_wr_en, f1_wr_en, f0_rd_en, f1_rd_en}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_flags", {win_vld, frame_done, sof_err}, 0);
        chk("rst_win_data", win_data, 0);
        @(posedge clk); #1;
    endtask

    task automatic stall_f1(input logic [DW-1:0] d);
        f1_hold = 1'b1;
        in_vld = 1'b1;
        in_data = d;
        in_sof = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_quiet", {in_rdy, f0_rd_en, f1_rd_en, f0_wr_en, f1_wr_en, win_vld}, 0);
        end
        @(posedge clk); #1;
        f1_hold = 1'b0;
    endtask

    typedef struct {
        int   base;
        int   sof_px;
        int   stall_px;
        int   rst_px;
        logic exp_err;
        int   exp_wins;
    } vec_t;

    task automatic run_vec(input vec_t v);
        bit ok;
        int g0, p0b, p1b, db, r, c;
        logic [9*DW-1:0] exp_q[$];
        logic [9*DW-1:0] last_w;
        do_reset();
        if (v.rst_px > 0) begin
            for (int k = 1; k < v.rst_px; k++) send_px(DW'(v.base + k), k == 1, ok);
            rst = 1'b1;
            in_vld = 1'b1;
            in_data = DW'(v.base + v.rst_px);
            @(negedge clk);
            chk("midrst_fifo_en", {f0_wr_en, f1_wr_en, f0_rd_en, f1_rd_en}, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("midrst_outs", {win_vld, frame_done, sof_err, in_rdy, f0_wr_en, f1_wr_en, f0_rd_en, f1_rd_en}, 0);
            @(posedge clk); #1;
            rst = 1'b0;
            in_vld = 1'b0;
            @(negedge clk);
            chk("midrst_in_rdy", in_rdy, 1);
            @(posedge clk); #1;
        end
        g0 = got_q.size();
        last_w = '0;
        for (int k = 1; k <= W*H; k++) begin
            if (k == v.stall_px) stall_f1(DW'(v.base + k));
            send_px(DW'(v.base + k), (k == 1) || (k == v.sof_px), ok);
            r = (k - 1) / W;
            c = (k - 1) % W;
            if (ok && r == H - 1 && c >= 2) begin
                last_w = exp_win(v.base, c);
                exp_q.push_back(last_w);
            end
        end
        p0b = pop0_n;
        p1b = pop1_n;
        db = done_n;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (done_n != db) break;
        end
        chk("frame_done_seen", (done_n != db), 1);
        @(negedge clk);
        chk("idle_in_rdy", in_rdy, 1);
        repeat (2) @(negedge clk);
        chk("frame_done_pulses", done_n - db, 1);
        chk("drain_pops_f0", pop0_n - p0b, W);
        chk("drain_pops_f1", pop1_n - p1b, W);
        chk("done_after_pop", done_cyc - pop_cyc, 1);
        chk("sof_err", sof_err, v.exp_err);
        chk("win_count", got_q.size() - g0, v.exp_wins);
        for (int i = 0; i < exp_q.size() && (g0 + i) < got_q.size(); i++)
            chk("win_data", got_q[g0 + i], exp_q[i]);
        chk("win_held", win_data, last_w);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vecs[5];
        bit ok;
        int w0b, w1b, gb;
        vecs[0] = '{base: 0,     sof_px: 0, stall_px: 0,  rst_px: 0, exp_err: 1'b0, exp_wins: 2};
        vecs[1] = '{base: 0,     sof_px: 6, stall_px: 0,  rst_px: 0, exp_err: 1'b1, exp_wins: 2};
        vecs[2] = '{base: 'h10,  sof_px: 0, stall_px: 10, rst_px: 0, exp_err: 1'b0, exp_wins: 2};
        vecs[3] = '{base: 'h20,  sof_px: 0, stall_px: 0,  rst_px: 7, exp_err: 1'b0, exp_wins: 2};
        vecs[4] = '{base: 'hE0,  sof_px: 3, stall_px: 11, rst_px: 0, exp_err: 1'b1, exp_wins: 2};

        // Pixels without SOF while idle must be swallowed.
        do_reset();
        w0b = wr0_n;
        w1b = wr1_n;
        gb = got_q.size();
        for (int k = 0; k < 5; k++) send_px(DW'(8'h40 + k), 1'b0, ok);
        @(negedge clk);
        chk("idle_no_wr", {wr0_n - w0b, wr1_n - w1b}, 0);
        chk("idle_no_win", got_q.size() - gb, 0);
        chk("idle_rdy", in_rdy, 1);
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        chk("fifo_protocol", proto_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
